spram_req_ctrl: RTL and testbench

//  Request front-end sitting directly upstream of xpm_memory_spram (1-cycle read latency).

---
 rtl/spram_ctrl_pkg.sv | 23 ++
 rtl/spram_rsp_fifo.sv | 73 +++++++
 rtl/spram_rsp_fifo_chk.sv | 17 +
 rtl/spram_req_ctrl.sv | 154 +++++++++++++++
 tb/tb_spram_req_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spram_ctrl_pkg.sv
// Shared types and helpers for the SPRAM request front-end.
// The response entry uses the default line width; other widths pack {err, data} directly.
package spram_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH_A = 10;
  localparam int DEF_DATA_WIDTH   = 512;
  localparam int DEF_MEMORY_SIZE  = 4096;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_t;

  typedef struct packed {
    logic                      err;
    logic [DEF_DATA_WIDTH-1:0] data;
  } rsp_entry_t;

  function automatic int lines_f(input int memory_size, input int data_width);
    return memory_size / data_width;
  endfunction

endpackage

// File: rtl/spram_rsp_fifo.sv
// Two-entry in-order response buffer; the head entry stays stable until popped.
module spram_rsp_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [2];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify push/pop against occupancy; a pop frees the slot a simultaneous push fills.
  always_comb begin
    pop_ok_s  = pop & (count_r != 2'd0);
    push_ok_s = push & ((count_r != 2'd2) | pop_ok_s);
  end

  // Storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r[0] <= {WIDTH{1'b0}};
      mem_r[1] <= {WIDTH{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 2'd0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == 2'd2);
  assign empty = (count_r == 2'd0);

  spram_rsp_fifo_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop_ok_s),
    .count (count_r)
  );

endmodule

// File: rtl/spram_rsp_fifo_chk.sv
// Protocol checks for the 2-entry response FIFO.
module spram_rsp_fifo_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       push,
  input logic       pop,
  input logic [1:0] count
);

  // A push into a full FIFO without a matching pop would lose a response.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == 2'd2)));

  a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
    count <= 2'd2);

endmodule

// File: rtl/spram_req_ctrl.sv
// Request front-end for a 1-cycle-latency single-port RAM: zero-fill after reset,
// valid/ready request issue, credit-limited reads returned in order through a 2-entry buffer.
module spram_req_ctrl
  import spram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH_A = DEF_ADDR_WIDTH_A,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int MEMORY_SIZE  = DEF_MEMORY_SIZE,
  parameter int INIT_ZERO    = 1
) (
  input  logic                    clka,
  input  logic                    rsta_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH_A-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    init_done,
  output logic                    mem_ena,
  output logic                    mem_wea,
  output logic [ADDR_WIDTH_A-1:0] mem_addra,
  output logic [DATA_WIDTH-1:0]   mem_dina,
  output logic                    mem_rsta,
  input  logic [DATA_WIDTH-1:0]   mem_douta
);

  localparam int                      LINES     = lines_f(MEMORY_SIZE, DATA_WIDTH);
  localparam logic [ADDR_WIDTH_A-1:0] LAST_LINE = ADDR_WIDTH_A'(LINES - 1);
  localparam logic [ADDR_WIDTH_A-1:0] CNT_ONE   = ADDR_WIDTH_A'(1);
  localparam int                      RSP_W     = DATA_WIDTH + 1;

  ctrl_state_t             state_r;
  logic [ADDR_WIDTH_A-1:0] init_cnt_r;
  logic                    init_done_r;
  logic                    inflight_r;
  logic                    inflight_err_r;

  logic                    in_range_s;
  logic                    rd_credit_s;
  logic                    req_ready_s;
  logic                    req_fire_s;
  logic                    rd_fire_s;
  logic                    rsp_pop_s;
  logic [RSP_W-1:0]        push_data_s;
  logic [RSP_W-1:0]        fifo_dout_s;
  logic [1:0]              fifo_count_s;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;

  // Handshake and read credit: a read needs a slot counting both buffered and in-flight data.
  always_comb begin
    in_range_s  = (32'(req_addr) < 32'(LINES));
    rd_credit_s = ~fifo_full_s & ((fifo_count_s == 2'd0) | ~inflight_r);
    req_ready_s = (state_r == RUN) & (req_we | rd_credit_s);
    req_fire_s  = req_valid & req_ready_s;
    rd_fire_s   = req_fire_s & ~req_we;
  end

  // SPRAM port mux: zero-fill writes in INIT, the accepted request in RUN.
  always_comb begin
    mem_ena   = 1'b0;
    mem_wea   = 1'b0;
    mem_addra = {ADDR_WIDTH_A{1'b0}};
    mem_dina  = {DATA_WIDTH{1'b0}};
    if (state_r == INIT) begin
      // Gate with reset so the port is idle while reset is held.
      mem_ena   = rsta_n & (INIT_ZERO != 0);
      mem_wea   = rsta_n & (INIT_ZERO != 0);
      mem_addra = init_cnt_r;
    end else begin
      mem_ena   = req_fire_s & in_range_s;
      mem_wea   = req_fire_s & in_range_s & req_we;
      mem_addra = req_fire_s ? req_addr : {ADDR_WIDTH_A{1'b0}};
      mem_dina  = (req_fire_s & req_we) ? req_wdata : {DATA_WIDTH{1'b0}};
    end
  end

  // Control FSM and zero-fill line counter.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_r     <= INIT;
      init_cnt_r  <= {ADDR_WIDTH_A{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      case (state_r)
        INIT: begin
          if ((INIT_ZERO == 0) || (init_cnt_r == LAST_LINE)) begin
            state_r     <= RUN;
            init_done_r <= 1'b1;
            init_cnt_r  <= {ADDR_WIDTH_A{1'b0}};
          end else begin
            init_cnt_r  <= init_cnt_r + CNT_ONE;
          end
        end
        RUN: begin
          state_r     <= RUN;
          init_done_r <= 1'b1;
        end
        default: begin
          state_r     <= INIT;
          init_cnt_r  <= {ADDR_WIDTH_A{1'b0}};
          init_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Track the read issued last cycle; its douta (or a zero error entry) lands in the FIFO now.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      inflight_r     <= 1'b0;
      inflight_err_r <= 1'b0;
    end else begin
      inflight_r     <= rd_fire_s;
      inflight_err_r <= rd_fire_s & ~in_range_s;
    end
  end

  // Response entry packing.
  always_comb begin
    if (inflight_err_r) begin
      push_data_s = {1'b1, {DATA_WIDTH{1'b0}}};
    end else begin
      push_data_s = {1'b0, mem_douta};
    end
    rsp_pop_s = ~fifo_empty_s & rsp_ready;
  end

  spram_rsp_fifo #(
    .WIDTH (RSP_W)
  ) u_rsp_fifo (
    .clk   (clka),
    .rst_n (rsta_n),
    .push  (inflight_r),
    .din   (push_data_s),
    .pop   (rsp_pop_s),
    .dout  (fifo_dout_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign req_ready = req_ready_s;
  assign rsp_valid = ~fifo_empty_s;
  assign rsp_err   = fifo_dout_s[DATA_WIDTH];
  assign rsp_rdata = fifo_dout_s[DATA_WIDTH-1:0];
  assign init_done = init_done_r;
  assign mem_rsta  = (state_r == INIT);

endmodule

// File: tb/tb_spram_req_ctrl.sv
// Self-checking bench for spram_req_ctrl with a behavioural 1-cycle SPRAM and a
// line-array/queue reference model of request and response ordering.
module tb_spram_req_ctrl;
  import spram_ctrl_pkg::*;

  logic         clka;
  logic         rsta_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [9:0]   req_addr;
  logic [511:0] req_wdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [511:0] rsp_rdata;
  logic         rsp_err;
  logic         init_done;
  logic         mem_ena;
  logic         mem_wea;
  logic [9:0]   mem_addra;
  logic [511:0] mem_dina;
  logic         mem_rsta;
  logic [511:0] spram_dout;

  int checks = 0;
  int errors = 0;

  // reference model: line contents and expected responses in order
  logic [511:0] ref_mem [8];
  rsp_entry_t   exp_q [$];
  rsp_entry_t   exp_rsp;

  // per-cycle observations from tick()
  logic         s_req_ready, s_rsp_valid, s_rsp_err, s_init_done;
  logic         s_mem_ena, s_mem_rsta;
  logic [9:0]   s_mem_addra;
  logic [511:0] s_rsp_rdata;
  logic         req_fire, rsp_fire, rsp_unexp;
  int           pre_out;

  spram_req_ctrl dut (
    .clka      (clka),
    .rsta_n    (rsta_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_done (init_done),
    .mem_ena   (mem_ena),
    .mem_wea   (mem_wea),
    .mem_addra (mem_addra),
    .mem_dina  (mem_dina),
    .mem_rsta  (mem_rsta),
    .mem_douta (spram_dout)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // behavioural single-port RAM, 1-cycle read latency, output latch reset by rsta
  logic [511:0] spram_mem [1024];
  always @(posedge clka) begin
    if (mem_rsta) spram_dout <= '0;
    else if (mem_ena && !mem_wea) spram_dout <= spram_mem[mem_addra];
    if (mem_ena && mem_wea) spram_mem[mem_addra] <= mem_dina;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [511:0] rand_line();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    for (int k = 0; k < 8; k++) ref_mem[k] = '0;
  endtask

  // sample one cycle at the falling edge, update the model on handshakes, advance past the rising edge
  task automatic tick();
    rsp_entry_t e;
    @(negedge clka);
    s_req_ready = req_ready;  s_rsp_valid = rsp_valid;  s_rsp_rdata = rsp_rdata;
    s_rsp_err   = rsp_err;    s_init_done = init_done;  s_mem_ena   = mem_ena;
    s_mem_rsta  = mem_rsta;   s_mem_addra = mem_addra;
    pre_out   = exp_q.size();
    req_fire  = req_valid && req_ready;
    rsp_fire  = rsp_valid && rsp_ready;
    rsp_unexp = 1'b0;
    if (rsp_fire) begin
      if (exp_q.size() > 0) exp_rsp = exp_q.pop_front();
      else rsp_unexp = 1'b1;
    end
    if (req_fire) begin
      if (req_we) begin
        if (req_addr < 10'd8) ref_mem[req_addr[2:0]] = req_wdata;
      end else begin
        e.err  = (req_addr >= 10'd8);
        e.data = (req_addr < 10'd8) ? ref_mem[req_addr[2:0]] : 512'd0;
        exp_q.push_back(e);
      end
    end
    @(posedge clka);
    #1;
  endtask

  task automatic test_reset();
    logic got;
    rsta_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd5;
    req_wdata = '0; rsp_ready = 1'b1;
    model_clear();
    #23;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || init_done !== 1'b0 || mem_ena !== 1'b0 ||
        mem_wea !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 512'd0 || mem_addra !== 10'd0 ||
        mem_dina !== 512'd0)
      begin errors++; $display("FAIL reset_outputs got valid=%b ready=%b done=%b ena=%b wea=%b err=%b exp all 0",
        rsp_valid, req_ready, init_done, mem_ena, mem_wea, rsp_err); end
    checks++;
    if (mem_rsta !== 1'b1) begin errors++; $display("FAIL reset_rsta got=%b exp=1", mem_rsta); end
    @(posedge clka); #1;
    rsta_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (s_req_ready !== 1'b0 || s_init_done !== 1'b0 || s_mem_ena !== 1'b1 || s_mem_rsta !== 1'b1 ||
          s_mem_addra !== 10'(i))
        begin errors++; $display("FAIL init_cycle%0d got ready=%b done=%b ena=%b rsta=%b addr=%0d exp 0,0,1,1,%0d",
          i, s_req_ready, s_init_done, s_mem_ena, s_mem_rsta, s_mem_addra, i); end
    end
    tick();
    checks++;
    if (s_init_done !== 1'b1 || !req_fire)
      begin errors++; $display("FAIL init_done_accept got done=%b fire=%b exp 1,1", s_init_done, req_fire); end
    req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      tick();
      if (rsp_fire) begin
        got = 1'b1;
        checks++;
        if (rsp_unexp || s_rsp_rdata !== exp_rsp.data || s_rsp_rdata !== 512'd0 || s_rsp_err !== 1'b0)
          begin errors++; $display("FAIL read_after_init got=%h err=%b exp=0 err=0", s_rsp_rdata, s_rsp_err); end
      end
    end
    if (!got) begin checks++; errors++; $display("FAIL read_after_init_timeout got=none exp=response"); end
  endtask

  task automatic test_write_read();
    logic [511:0] pat;
    pat = {64{8'hA5}};
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd3; req_wdata = pat;
    tick();
    checks++;
    if (!req_fire) begin errors++; $display("FAIL wr3_accept got=%b exp=1", req_fire); end
    req_we = 1'b0;
    tick();
    checks++;
    if (!req_fire) begin errors++; $display("FAIL rd3_accept got=%b exp=1", req_fire); end
    req_valid = 1'b0;
    tick();
    checks++;
    if (s_rsp_valid !== 1'b0) begin errors++; $display("FAIL rd3_latency1 got valid=%b exp=0", s_rsp_valid); end
    tick();
    checks++;
    if (s_rsp_valid !== 1'b1 || rsp_unexp || s_rsp_rdata !== pat || s_rsp_rdata !== exp_rsp.data || s_rsp_err !== 1'b0)
      begin errors++; $display("FAIL rd3_data got valid=%b data=%h err=%b exp valid=1 data=%h err=0",
        s_rsp_valid, s_rsp_rdata, s_rsp_err, pat); end
  endtask

  task automatic test_backpressure();
    logic [511:0] got [3];
    int n, acc_idx, first_idx;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1;
    for (int a = 0; a < 3; a++) begin
      req_addr = 10'(a); req_wdata = 512'(10 + a);
      tick();
      checks++;
      if (!req_fire) begin errors++; $display("FAIL bp_wr%0d got=%b exp=1", a, req_fire); end
    end
    rsp_ready = 1'b0; req_we = 1'b0;
    req_addr = 10'd0; tick();
    checks++;
    if (!req_fire) begin errors++; $display("FAIL bp_rd0_accept got=%b exp=1", req_fire); end
    req_addr = 10'd1; tick();
    checks++;
    if (!req_fire) begin errors++; $display("FAIL bp_rd1_accept got=%b exp=1", req_fire); end
    req_addr = 10'd2;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (s_req_ready !== 1'b0) begin errors++; $display("FAIL bp_credit_stall%0d got ready=%b exp=0", i, s_req_ready); end
    end
    rsp_ready = 1'b1;
    n = 0; acc_idx = -1; first_idx = -1;
    for (int i = 0; i < 10 && n < 3; i++) begin
      tick();
      if (req_fire) begin acc_idx = i; req_valid = 1'b0; end
      if (rsp_fire) begin
        if (n == 0) first_idx = i;
        got[n] = s_rsp_rdata;
        checks++;
        if (rsp_unexp || s_rsp_rdata !== exp_rsp.data || s_rsp_err !== exp_rsp.err)
          begin errors++; $display("FAIL bp_model%0d got=%h exp=%h", n, s_rsp_rdata, exp_rsp.data); end
        n++;
      end
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL bp_count got=%0d exp=3", n); end
    else begin
      checks++;
      if (got[0] !== 512'd10 || got[1] !== 512'd11 || got[2] !== 512'd12)
        begin errors++; $display("FAIL bp_order got=%0d,%0d,%0d exp=10,11,12", got[0], got[1], got[2]); end
    end
    checks++;
    if (acc_idx < 0 || acc_idx <= first_idx)
      begin errors++; $display("FAIL bp_third_accept got idx=%0d exp after %0d", acc_idx, first_idx); end
    req_valid = 1'b0;
  endtask

  task automatic test_out_of_range();
    logic got;
    int n, a;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd9;
    tick();
    checks++;
    if (!req_fire || s_mem_ena !== 1'b0)
      begin errors++; $display("FAIL oor_rd_issue got fire=%b ena=%b exp 1,0", req_fire, s_mem_ena); end
    req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      tick();
      if (rsp_fire) begin
        got = 1'b1;
        checks++;
        if (rsp_unexp || s_rsp_rdata !== 512'd0 || s_rsp_err !== 1'b1 || exp_rsp.err !== 1'b1)
          begin errors++; $display("FAIL oor_rd_rsp got data=%h err=%b exp data=0 err=1", s_rsp_rdata, s_rsp_err); end
      end
    end
    if (!got) begin checks++; errors++; $display("FAIL oor_rd_timeout got=none exp=response"); end
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd9; req_wdata = rand_line();
    tick();
    checks++;
    if (!req_fire || s_mem_ena !== 1'b0)
      begin errors++; $display("FAIL oor_wr_issue got fire=%b ena=%b exp 1,0", req_fire, s_mem_ena); end
    req_we = 1'b0; a = 0; n = 0;
    req_addr = 10'd0;
    for (int i = 0; i < 40 && n < 8; i++) begin
      tick();
      if (req_fire) begin
        a++;
        if (a < 8) req_addr = 10'(a); else req_valid = 1'b0;
      end
      if (rsp_fire) begin
        checks++;
        if (rsp_unexp || s_rsp_rdata !== exp_rsp.data || s_rsp_err !== 1'b0)
          begin errors++; $display("FAIL oor_readback%0d got=%h exp=%h", n, s_rsp_rdata, exp_rsp.data); end
        n++;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (n != 8) begin errors++; $display("FAIL oor_readback_count got=%0d exp=8", n); end
  endtask

  task automatic test_reset_mid();
    logic got;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd0;
    tick();
    req_addr = 10'd1;
    tick();
    checks++;
    if (!req_fire || rsp_valid !== 1'b1)
      begin errors++; $display("FAIL midrst_setup got fire=%b valid=%b exp 1,1", req_fire, rsp_valid); end
    rsta_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || mem_rsta !== 1'b1 || req_ready !== 1'b0)
      begin errors++; $display("FAIL midrst_immediate got valid=%b rsta=%b ready=%b exp 0,1,0", rsp_valid, mem_rsta, req_ready); end
    model_clear();
    @(posedge clka); #1;
    rsta_n = 1'b1; rsp_ready = 1'b1; req_addr = 10'd0;
    for (int i = 0; i < 11; i++) begin
      if (i == 8) req_valid = 1'b0;
      tick();
      checks++;
      if (s_rsp_valid !== 1'b0 || (i < 8 && (s_req_ready !== 1'b0 || s_mem_ena !== 1'b1)))
        begin errors++; $display("FAIL midrst_refill%0d got valid=%b ready=%b ena=%b exp 0,0,1", i, s_rsp_valid, s_req_ready, s_mem_ena); end
    end
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      tick();
      if (rsp_fire) begin
        got = 1'b1;
        checks++;
        if (rsp_unexp || s_rsp_rdata !== 512'd0 || s_rsp_rdata !== exp_rsp.data || s_rsp_err !== 1'b0)
          begin errors++; $display("FAIL midrst_zeroed got=%h err=%b exp=0 err=0", s_rsp_rdata, s_rsp_err); end
      end
    end
    if (!got) begin checks++; errors++; $display("FAIL midrst_read_timeout got=none exp=response"); end
  endtask

  task automatic test_random();
    logic         stall_prev;
    logic [511:0] data_prev;
    logic         err_prev;
    stall_prev = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      req_valid = ($urandom_range(0, 9) < 7);
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = 10'($urandom_range(0, 9));
      req_wdata = rand_line();
      rsp_ready = ($urandom_range(0, 9) < 6);
      tick();
      if (req_valid) begin
        checks++;
        if (s_req_ready !== (req_we ? 1'b1 : (pre_out < 2)))
          begin errors++; $display("FAIL rnd_ready c=%0d got=%b exp=%b we=%b out=%0d", c, s_req_ready, (req_we ? 1'b1 : (pre_out < 2)), req_we, pre_out); end
      end
      checks++;
      if (exp_q.size() > 2) begin errors++; $display("FAIL rnd_overflow c=%0d got=%0d exp<=2", c, exp_q.size()); end
      if (stall_prev) begin
        checks++;
        if (s_rsp_valid !== 1'b1 || s_rsp_rdata !== data_prev || s_rsp_err !== err_prev)
          begin errors++; $display("FAIL rnd_hold c=%0d got=%h exp=%h", c, s_rsp_rdata, data_prev); end
      end
      if (rsp_fire) begin
        checks++;
        if (rsp_unexp || s_rsp_rdata !== exp_rsp.data || s_rsp_err !== exp_rsp.err)
          begin errors++; $display("FAIL rnd_data c=%0d got=%h/%b exp=%h/%b", c, s_rsp_rdata, s_rsp_err, exp_rsp.data, exp_rsp.err); end
      end
      stall_prev = s_rsp_valid && !rsp_ready;
      data_prev  = s_rsp_rdata;
      err_prev   = s_rsp_err;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_fire) begin
        checks++;
        if (rsp_unexp || s_rsp_rdata !== exp_rsp.data || s_rsp_err !== exp_rsp.err)
          begin errors++; $display("FAIL rnd_drain got=%h exp=%h", s_rsp_rdata, exp_rsp.data); end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_backpressure();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
